// File: rtl/alu_stage_if.sv
// Operand/result handshake bundle for the ALU stage.
interface alu_stage_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [5:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;

    // Environment side: supplies operands, consumes results.
    modport master (
        output in_valid, x, y, ctrl, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );

    // Stage side: accepts operands, presents registered results.
    modport slave (
        input  in_valid, x, y, ctrl, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
endinterface

// File: rtl/alu_stage.sv
// Single-cycle Hack-style ALU with a registered output entry and a skid entry.
module alu_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    alu_stage_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zr;
        logic             ng;
    } entry_t;

    entry_t out_q;
    entry_t skid_q;
    entry_t new_c;
    logic   out_valid_q;
    logic   skid_valid_q;
    logic   accept_c;
    logic   take_c;

    logic [WIDTH-1:0] x1_c, x2_c, y1_c, y2_c, r_c, res_c;

    // ALU datapath: zero/negate each operand, add or AND, optional output negate.
    always_comb begin
        x1_c  = bus.ctrl[5] ? '0 : bus.x;
        x2_c  = bus.ctrl[4] ? ~x1_c : x1_c;
        y1_c  = bus.ctrl[3] ? '0 : bus.y;
        y2_c  = bus.ctrl[2] ? ~y1_c : y1_c;
        r_c   = bus.ctrl[1] ? WIDTH'(x2_c + y2_c) : (x2_c & y2_c);
        res_c = bus.ctrl[0] ? ~r_c : r_c;
        new_c.data = res_c;
        new_c.zr   = (res_c == '0);
        new_c.ng   = res_c[WIDTH-1];
    end

    // Handshake qualifiers.
    always_comb begin
        accept_c = bus.in_valid & bus.in_ready;
        take_c   = out_valid_q & bus.out_ready;
    end

    // Output/skid entry management; skid drains first to keep accept order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || take_c) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept_c) begin
                out_q       <= new_c;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept_c) begin
            skid_q       <= new_c;
            skid_valid_q <= 1'b1;
        end
    end

    // Ready depends only on the skid register, held low during reset.
    assign bus.in_ready  = ~skid_valid_q & ~reset;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q.data;
    assign bus.zr        = out_q.zr;
    assign bus.ng        = out_q.ng;
endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: datapath vectors, backpressure, throughput, reset.
module tb_alu_stage;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_stage_if #(.WIDTH(16)) bus ();

    alu_stage #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU written directly from the control-bit definitions.
    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [5:0] c);
        logic [15:0] xa, yb, r;
        xa = c[5] ? 16'h0000 : a;
        if (c[4]) xa = ~xa;
        yb = c[3] ? 16'h0000 : b;
        if (c[2]) yb = ~yb;
        if (c[1]) r = 16'(xa + yb);
        else      r = xa & yb;
        if (c[0]) r = ~r;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [15:0] exp);
        check({tag, ".out"}, 32'(bus.out), 32'(exp));
        check({tag, ".zr"}, 32'(bus.zr), 32'(exp == 16'h0000));
        check({tag, ".ng"}, 32'(bus.ng), 32'(exp[15]));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] c, input logic [15:0] exp);
        bus.x        = a;
        bus.y        = b;
        bus.ctrl     = c;
        bus.in_valid = 1'b1;
        tick();
        check_result(tag, exp);
    endtask

    initial begin
        logic [15:0] rx, ry, rexp;
        logic [5:0]  rc;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = 16'h0000;
        bus.y         = 16'h0000;
        bus.ctrl      = 6'b000000;
        tick();
        tick();
        check("rst.in_ready", 32'(bus.in_ready), 32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out", 32'(bus.out), 32'h0);
        check("rst.zr", 32'(bus.zr), 32'd0);
        check("rst.ng", 32'(bus.ng), 32'd0);

        reset = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst.out_valid", 32'(bus.out_valid), 32'd0);

        // Datapath vectors with full-throughput streaming.
        bus.out_ready = 1'b1;
        do_op("add5_3", 16'h0005, 16'h0003, 6'b000010, 16'h0008);
        do_op("and5_3", 16'h0005, 16'h0003, 6'b000000, 16'h0001);
        do_op("neg1",   16'h0005, 16'h0003, 6'b111010, 16'hFFFF);
        do_op("zero",   16'h0005, 16'h0003, 6'b101010, 16'h0000);
        do_op("ovf",    16'h7FFF, 16'h0001, 6'b000010, 16'h8000);
        do_op("carry",  16'hFFFF, 16'h0001, 6'b000010, 16'h0000);
        do_op("x_min_y", 16'h0005, 16'h0003, 6'b010011, 16'h0002);
        do_op("y_min_x", 16'h0005, 16'h0003, 6'b000111, 16'hFFFE);

        bus.in_valid = 1'b0;
        tick();
        check("drain.out_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: A to output, B to skid, C held off; then drain in order.
        bus.out_ready = 1'b0;
        do_op("bp.A", 16'h0001, 16'h0002, 6'b000010, 16'h0003);
        check("bp.A.in_ready", 32'(bus.in_ready), 32'd1);
        do_op("bp.B", 16'h000A, 16'h0014, 6'b000010, 16'h0003);
        check("bp.B.in_ready", 32'(bus.in_ready), 32'd0);
        do_op("bp.C_held", 16'h0100, 16'h0200, 6'b000010, 16'h0003);
        check("bp.C_held.in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check_result("bp.B_out", 16'h001E);
        check("bp.B_out.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_result("bp.C_out", 16'h0300);
        bus.in_valid = 1'b0;
        tick();
        check("bp.drained", 32'(bus.out_valid), 32'd0);

        // Twenty back-to-back random operand sets.
        for (int i = 0; i < 20; i++) begin
            rx   = 16'($urandom);
            ry   = 16'($urandom);
            rc   = 6'($urandom);
            rexp = ref_alu(rx, ry, rc);
            do_op($sformatf("rnd%0d", i), rx, ry, rc, rexp);
        end
        bus.in_valid = 1'b0;
        tick();
        check("rnd.drained", 32'(bus.out_valid), 32'd0);

        // Fill both entries, then reset mid-operation.
        bus.out_ready = 1'b0;
        do_op("rr.D", 16'h1111, 16'h2222, 6'b000010, 16'h3333);
        do_op("rr.E", 16'h0001, 16'h0001, 6'b000010, 16'h3333);
        check("rr.full.in_ready", 32'(bus.in_ready), 32'd0);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.x        = 16'h0042;
        tick();
        check("rr.in_rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rr.in_rst.out", 32'(bus.out), 32'h0);
        check("rr.in_rst.in_ready", 32'(bus.in_ready), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rr.after.in_ready", 32'(bus.in_ready), 32'd1);
        check("rr.after.out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rr.no_stale%0d", i), 32'(bus.out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
